// File: rtl/video_capture_pkg.sv
// Shared constants and FSM state encoding for the frame-capture path.
// Keep in step with the scan-out timing generator so a captured frame redisplays unchanged.
package video_capture_pkg;

    localparam int DEF_H_PIX    = 16;
    localparam int DEF_V_LIN    = 12;
    localparam int PIX_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_ARMED = 3'd2,
        ST_FRAME = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_e;

endpackage

// File: rtl/video_capture_deser.sv
// Serial-to-nibble deserialiser: 4-bit LSB-first shift register and a 2-bit
// pixel counter. nib_rdy_o flags the cycle in which the 4th pixel is shifted in.
module video_capture_deser (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_i,
    input  logic       clr_i,
    input  logic       pixel_i,
    output logic [3:0] sr_o,
    output logic       nib_rdy_o
);

    logic [3:0] sr_q;
    logic [1:0] pix_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            pix_q <= '0;
        end else if (shift_i) begin
            sr_q  <= {pixel_i, sr_q[3:1]};
            pix_q <= pix_q + 2'd1;
        end else if (clr_i) begin
            // Drops any partial nibble left over from a short line.
            pix_q <= '0;
        end
    end

    assign sr_o      = sr_q;
    assign nib_rdy_o = shift_i & (pix_q == 2'd3);

endmodule

// File: rtl/video_capture.sv
// Frame grabber: packs a blank-qualified 1-bit pixel stream into nibbles and
// writes them to video memory at {line, word}; armed per frame by start/busy/done.
module video_capture
    import video_capture_pkg::*;
#(
    parameter int H_PIX = DEF_H_PIX,
    parameter int V_LIN = DEF_V_LIN,
    parameter int AW    = $clog2(V_LIN) + $clog2(H_PIX / PIX_PER_WORD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          pixel_in,
    input  logic          hblank_in,
    input  logic          vblank_in,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_dat,
    output logic          line_err,
    output logic          frame_err
);

    localparam int LINE_W = $clog2(V_LIN);
    localparam int WORD_W = AW - LINE_W;
    localparam int CNT_W  = $clog2(H_PIX) + 2;

    localparam logic [LINE_W:0]  LINE_LIM = (LINE_W + 1)'(V_LIN);
    localparam logic [WORD_W:0]  WORD_LIM = (WORD_W + 1)'(H_PIX / PIX_PER_WORD);
    localparam logic [CNT_W-1:0] PIX_LIM  = CNT_W'(H_PIX);

    function automatic logic [LINE_W:0] sat_line(input logic [LINE_W:0] v);
        return (&v) ? v : v + (LINE_W + 1)'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    cap_state_e       state_q;
    logic             busy_q, done_q, line_err_q, frame_err_q;
    logic             hb_q, vb_q;
    logic [LINE_W:0]  line_q;
    logic [WORD_W:0]  word_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_pend_q;
    logic [AW-1:0]    wr_addr_q;
    logic             mem_we_q;
    logic [AW-1:0]    mem_addr_q;
    logic [3:0]       mem_dat_q;

    logic             vis, capture, line_end, frame_end, in_range, clr_pix;
    logic             nib_rdy;
    logic [3:0]       sr;
    logic [LINE_W:0]  line_nx;

    assign vis      = ~hblank_in & ~vblank_in;
    assign capture  = vis & ((state_q == ST_FRAME) | (state_q == ST_ARMED));
    // A line ends on hblank rise unless vblank was already active; this also
    // catches an hblank rise coinciding with the vblank rise.
    assign line_end  = (state_q == ST_FRAME) & hblank_in & ~hb_q & ~vb_q;
    assign frame_end = (state_q == ST_FRAME) & vblank_in & ~vb_q;
    assign in_range  = (word_q < WORD_LIM) & (line_q < LINE_LIM);
    assign clr_pix   = line_end | frame_end | (state_q == ST_IDLE);
    assign line_nx   = line_end ? sat_line(line_q) : line_q;

    video_capture_deser u_deser (
        .clk       (clk),
        .rst       (rst),
        .shift_i   (capture),
        .clr_i     (clr_pix),
        .pixel_i   (pixel_in),
        .sr_o      (sr),
        .nib_rdy_o (nib_rdy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            hb_q        <= 1'b0;
            vb_q        <= 1'b0;
            line_q      <= '0;
            word_q      <= '0;
            cnt_q       <= '0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_dat_q   <= '0;
        end else begin
            hb_q      <= hblank_in;
            vb_q      <= vblank_in;
            done_q    <= 1'b0;
            wr_pend_q <= 1'b0;

            // Write stage: the shift register holds the completed nibble for one cycle.
            mem_we_q <= wr_pend_q;
            if (wr_pend_q) begin
                mem_addr_q <= wr_addr_q;
                mem_dat_q  <= sr;
            end

            if (capture) begin
                cnt_q <= sat_cnt(cnt_q);
                if (nib_rdy) begin
                    if (in_range) begin
                        wr_pend_q <= 1'b1;
                        wr_addr_q <= {line_q[LINE_W-1:0], word_q[WORD_W-1:0]};
                    end
                    if (word_q < WORD_LIM) begin
                        word_q <= word_q + (WORD_W + 1)'(1);
                    end
                end
                if (line_q >= LINE_LIM) begin
                    frame_err_q <= 1'b1;
                end else if (cnt_q >= PIX_LIM) begin
                    line_err_q <= 1'b1;
                end
            end

            if (line_end) begin
                line_q <= line_nx;
                word_q <= '0;
                cnt_q  <= '0;
                if (cnt_q != PIX_LIM) begin
                    line_err_q <= 1'b1;
                end
            end

            if (frame_end) begin
                line_q <= '0;
                word_q <= '0;
                cnt_q  <= '0;
                if (line_nx != LINE_LIM) begin
                    frame_err_q <= 1'b1;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_SYNC;
                        busy_q      <= 1'b1;
                        line_err_q  <= 1'b0;
                        frame_err_q <= 1'b0;
                        line_q      <= '0;
                        word_q      <= '0;
                        cnt_q       <= '0;
                    end
                end
                ST_SYNC: begin
                    if (vblank_in) begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (vis) begin
                        state_q <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (frame_end) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_dat   = mem_dat_q;
    assign line_err  = line_err_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture: drives 19x14 raster frames and checks the
// memory write stream, handshake and error flags against hand-derived values.
module tb_video_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pixel_in = 1'b0;
    logic       hblank_in = 1'b0;
    logic       vblank_in = 1'b1;
    logic       busy, done, mem_we, line_err, frame_err;
    logic [5:0] mem_addr;
    logic [3:0] mem_dat;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [5:0] wr_addr[$];
    logic [3:0] wr_dat[$];

    always #5 clk = ~clk;

    video_capture dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pixel_in  (pixel_in),
        .hblank_in (hblank_in),
        .vblank_in (vblank_in),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_dat   (mem_dat),
        .line_err  (line_err),
        .frame_err (frame_err)
    );

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_dat.push_back(mem_dat);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Line pattern: line 0 starts with pixels 1,1,0,1 (nibble 0xB).
    function automatic logic [15:0] lp(input int l);
        return 16'h5A3B ^ (16'(l) * 16'h1111);
    endfunction

    task automatic cyc(input logic h, input logic v, input logic p, input logic s, input logic r);
        @(posedge clk);
        #1;
        hblank_in = h;
        vblank_in = v;
        pixel_in  = p;
        start     = s;
        rst       = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_start();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
    endtask

    task automatic drive_line(input int l, input int len, input logic s0);
        logic [15:0] w = lp(l);
        for (int c = 0; c < len; c++) cyc(1'b0, 1'b0, w[c % 16], (c == 0) ? s0 : 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vbl_lines(input int n, input int st_cols);
        for (int i = 0; i < n; i++)
            for (int c = 0; c < 19; c++)
                cyc(c >= 16, 1'b1, 1'b0, (i == 0) && (c < st_cols), 1'b0);
    endtask

    task automatic frame(input int nvis, input int long_l, input int long_len, input int st_cols);
        for (int l = 0; l < nvis; l++) drive_line(l, (l == long_l) ? long_len : 16, 1'b0);
        vbl_lines(2, st_cols);
    endtask

    // Expected: 48 writes in order, addr k, data = nibble k%4 of line k/4.
    task automatic check_frame(input string tag, input int base);
        int n = wr_addr.size() - base;
        int bad = 0;
        check({tag, "_wr_count"}, n, 48);
        for (int k = 0; k < n && k < 48; k++) begin
            logic [15:0] w = lp(k / 4);
            logic [3:0]  e = w[4 * (k % 4) +: 4];
            if (wr_addr[base + k] !== 6'(k) || wr_dat[base + k] !== e) bad++;
        end
        check({tag, "_wr_content_errs"}, bad, 0);
    endtask

    initial begin
        int b, d;
        logic [15:0] w1;

        // Reset state
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_dat", mem_dat, 0);
        check("rst_line_err", line_err, 0);
        check("rst_frame_err", frame_err, 0);
        idle(3);

        // 1: nominal frame
        b = wr_addr.size(); d = done_cnt;
        pulse_start();
        check("t1_busy_after_start", busy, 1);
        frame(12, -1, 0, 0);
        idle(2);
        check_frame("t1", b);
        check("t1_first_addr", (wr_addr.size() > b) ? 32'(wr_addr[b]) : 32'hFFFF, 0);
        check("t1_first_dat", (wr_dat.size() > b) ? 32'(wr_dat[b]) : 32'hFFFF, 32'hB);
        check("t1_done_pulses", done_cnt - d, 1);
        check("t1_line_err", line_err, 0);
        check("t1_frame_err", frame_err, 0);
        check("t1_busy_end", busy, 0);

        // 2: reset mid-frame after 5 writes
        b = wr_addr.size();
        pulse_start();
        drive_line(0, 16, 1'b0);
        w1 = lp(1);
        for (int c = 0; c < 6; c++) cyc(1'b0, 1'b0, w1[c], 1'b0, 1'b0);
        cyc(1'b0, 1'b0, w1[6], 1'b0, 1'b1);
        cyc(1'b0, 1'b0, w1[7], 1'b0, 1'b0);
        check("t2_busy_after_rst", busy, 0);
        check("t2_we_after_rst", mem_we, 0);
        check("t2_writes_before_rst", wr_addr.size() - b, 5);
        check("t2_fifth_addr", (wr_addr.size() > b + 4) ? 32'(wr_addr[b + 4]) : 32'hFFFF, 4);
        for (int c = 8; c < 16; c++) cyc(1'b0, 1'b0, w1[c], 1'b0, 1'b0);
        for (int l = 2; l < 12; l++) drive_line(l, 16, 1'b0);
        vbl_lines(2, 0);
        check("t2_idle_no_writes", wr_addr.size() - b, 5);
        check("t2_idle_busy", busy, 0);
        idle(3);
        b = wr_addr.size(); d = done_cnt;
        pulse_start();
        frame(12, -1, 0, 0);
        idle(2);
        check_frame("t2", b);
        check("t2_done_pulses", done_cnt - d, 1);
        check("t2_line_err", line_err, 0);
        check("t2_frame_err", frame_err, 0);

        // 3: start mid-frame waits for the next vblank
        b = wr_addr.size(); d = done_cnt;
        drive_line(0, 16, 1'b0);
        drive_line(1, 16, 1'b0);
        drive_line(2, 16, 1'b1);
        for (int l = 3; l < 12; l++) drive_line(l, 16, 1'b0);
        vbl_lines(2, 0);
        check("t3_no_write_partial", wr_addr.size() - b, 0);
        check("t3_busy_waiting", busy, 1);
        check("t3_no_done_yet", done_cnt - d, 0);
        frame(12, -1, 0, 0);
        idle(2);
        check_frame("t3", b);
        check("t3_first_addr", (wr_addr.size() > b) ? 32'(wr_addr[b]) : 32'hFFFF, 0);
        check("t3_done_pulses", done_cnt - d, 1);

        // 4: line 3 carries 18 visible pixels
        b = wr_addr.size();
        pulse_start();
        frame(12, 3, 18, 0);
        idle(2);
        check_frame("t4", b);
        check("t4_next_line_addr", (wr_addr.size() > b + 16) ? 32'(wr_addr[b + 16]) : 32'hFFFF, 16);
        check("t4_line_err", line_err, 1);
        check("t4_frame_err", frame_err, 0);

        // 5: 13 visible lines
        b = wr_addr.size(); d = done_cnt;
        pulse_start();
        check("t5_line_err_cleared", line_err, 0);
        frame(13, -1, 0, 0);
        idle(2);
        check_frame("t5", b);
        check("t5_frame_err", frame_err, 1);
        check("t5_line_err", line_err, 0);
        check("t5_done_pulses", done_cnt - d, 1);

        // 6: start high across the done cycle is ignored
        b = wr_addr.size(); d = done_cnt;
        pulse_start();
        frame(12, -1, 0, 2);
        idle(5);
        check("t6_busy_after_done", busy, 0);
        check("t6_done_pulses", done_cnt - d, 1);
        frame(12, -1, 0, 0);
        idle(2);
        check("t6_no_rearm_writes", wr_addr.size() - b, 48);
        check("t6_busy_still_low", busy, 0);
        pulse_start();
        check("t6_fresh_start_busy", busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
